// File: rtl/clock_pkg.sv
// Shared constants and types for the calendar clock front-end controller.
package clock_pkg;

  localparam int STATE_W = 5;

  // Field codes driven on o_state; every field counter decodes these.
  typedef enum logic [STATE_W-1:0] {
    FIELD_HOUR   = 5'd0,
    FIELD_MINUTE = 5'd1,
    FIELD_SECOND = 5'd2,
    FIELD_DAY    = 5'd3,
    FIELD_MONTH  = 5'd4,
    FIELD_YEAR   = 5'd5
  } field_t;

  // Mode FSM encoding.
  typedef logic [0:0] mode_state_t;
  localparam mode_state_t MODE_IDLE   = 1'b0;
  localparam mode_state_t MODE_MODIFY = 1'b1;

  // Step generator FSM encoding.
  typedef logic [1:0] step_state_t;
  localparam step_state_t S_IDLE  = 2'd0;
  localparam step_state_t S_PULSE = 2'd1;
  localparam step_state_t S_GAP   = 2'd2;

  typedef enum logic {
    DIR_PLUS  = 1'b0,
    DIR_MINUS = 1'b1
  } step_dir_t;

  // Advance the selected field, wrapping back to the first one.
  function automatic logic [STATE_W-1:0] next_field(input logic [STATE_W-1:0] cur,
                                                    input int unsigned num_fields);
    if (cur >= STATE_W'(num_fields - 1)) return FIELD_HOUR;
    return cur + STATE_W'(1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioning: two-flop synchronizer, stable-level filter
// and a one-cycle strobe on every accepted press.
module button_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS + 1) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button into the clock domain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the synchronized input disagrees with the accepted level.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
      // Counter is cleared on acceptance, so it never passes DEBOUNCE_MS-1.
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Accepted level and the strobe marking its rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/clock_control.sv
// Front-end controller for the calendar clock counters: 1 s enable square
// wave, modify/field selection and plus/minus step pulses with auto-repeat.
module clock_control
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter int TICK_MS         = 1000,
  parameter int PULSE_MS        = 2,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int NUM_FIELDS      = 6
) (
  input  logic               i_clk_0_001s,
  input  logic               i_reset,
  input  logic               i_btn_modify,
  input  logic               i_btn_mode,
  input  logic               i_btn_plus,
  input  logic               i_btn_minus,
  output logic               o_enable_1s,
  output logic [STATE_W-1:0] o_state,
  output logic               o_is_modify,
  output logic               o_plus,
  output logic               o_minus
);

  localparam int BTN_MODIFY = 0;
  localparam int BTN_MODE   = 1;
  localparam int BTN_PLUS   = 2;
  localparam int BTN_MINUS  = 3;

  localparam int TICK_W  = $clog2(TICK_MS);
  localparam int REP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  // ---------------- Buttons ----------------
  logic [3:0] btn_raw, btn_lvl, btn_press;
  logic       unused_levels;

  assign btn_raw = {i_btn_minus, i_btn_plus, i_btn_mode, i_btn_modify};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_debounce (
      .clk_i  (i_clk_0_001s),
      .rst_i  (i_reset),
      .btn_i  (btn_raw[i]),
      .level_o(btn_lvl[i]),
      .press_o(btn_press[i])
    );
  end

  // Modify and mode act on presses only; their held levels are not needed.
  assign unused_levels = btn_lvl[BTN_MODIFY] ^ btn_lvl[BTN_MODE];

  // ---------------- 1 s tick ----------------
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              enable_q;

  assign tick_d = (tick_q == TICK_W'(TICK_MS - 1)) ? '0 : tick_q + 1'b1;

  // Free-running tick counter; the enable follows the next count so its
  // first falling edge lands TICK_MS/2 cycles after reset release.
  always_ff @(posedge i_clk_0_001s or posedge i_reset) begin
    if (i_reset) begin
      tick_q   <= '0;
      enable_q <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      enable_q <= (tick_d < TICK_W'(TICK_MS / 2));
    end
  end

  // ---------------- Mode FSM ----------------
  mode_state_t        mode_q, mode_d;
  logic [STATE_W-1:0] field_q, field_d;

  // Modify press toggles mode (and wins over a simultaneous mode press);
  // mode press steps the field only while modifying.
  always_comb begin
    mode_d  = mode_q;
    field_d = field_q;
    if (btn_press[BTN_MODIFY]) begin
      if (mode_q == MODE_IDLE) begin
        mode_d  = MODE_MODIFY;
        field_d = FIELD_HOUR;
      end else begin
        mode_d = MODE_IDLE;
      end
    end else if (btn_press[BTN_MODE] && (mode_q == MODE_MODIFY)) begin
      field_d = next_field(field_q, NUM_FIELDS);
    end
  end

  // Mode and field registers.
  always_ff @(posedge i_clk_0_001s or posedge i_reset) begin
    if (i_reset) begin
      mode_q  <= MODE_IDLE;
      field_q <= '0;
    end else begin
      mode_q  <= mode_d;
      field_q <= field_d;
    end
  end

  // ---------------- Step generator ----------------
  step_state_t      step_q, step_d;
  step_dir_t        dir_q, dir_d;
  logic             first_q, first_d;
  logic [REP_W-1:0] rep_q, rep_d, rep_target;
  logic             plus_q, minus_q;
  logic             in_modify, one_held, dir_held, keep_stepping;

  assign in_modify     = (mode_q == MODE_MODIFY);
  assign one_held      = btn_lvl[BTN_PLUS] ^ btn_lvl[BTN_MINUS];
  assign dir_held      = (dir_q == DIR_PLUS) ? btn_lvl[BTN_PLUS] : btn_lvl[BTN_MINUS];
  assign keep_stepping = in_modify && one_held && dir_held;
  // rep_q counts cycles since the last rising edge, so targets are period-1.
  assign rep_target    = first_q ? REP_W'(REPEAT_DELAY_MS - 1) : REP_W'(REPEAT_RATE_MS - 1);

  // Pulse/gap sequencing; a started pulse always runs its full width.
  always_comb begin
    step_d  = step_q;
    dir_d   = dir_q;
    first_d = first_q;
    rep_d   = (rep_q == REP_W'(REP_MAX)) ? rep_q : rep_q + 1'b1;
    case (step_q)
      S_IDLE: begin
        rep_d = '0;
        if (in_modify && one_held && (btn_press[BTN_PLUS] || btn_press[BTN_MINUS])) begin
          step_d  = S_PULSE;
          dir_d   = btn_lvl[BTN_PLUS] ? DIR_PLUS : DIR_MINUS;
          first_d = 1'b1;
        end
      end
      S_PULSE: begin
        if (rep_q == REP_W'(PULSE_MS - 1)) step_d = S_GAP;
      end
      S_GAP: begin
        if (!keep_stepping) begin
          step_d = S_IDLE;
        end else if (rep_q == rep_target) begin
          step_d  = S_PULSE;
          first_d = 1'b0;
          rep_d   = '0;
        end
      end
      default: step_d = S_IDLE;
    endcase
  end

  // Step state and registered pulse outputs (glitch-free for edge-detecting consumers).
  always_ff @(posedge i_clk_0_001s or posedge i_reset) begin
    if (i_reset) begin
      step_q  <= S_IDLE;
      dir_q   <= DIR_PLUS;
      first_q <= 1'b0;
      rep_q   <= '0;
      plus_q  <= 1'b0;
      minus_q <= 1'b0;
    end else begin
      step_q  <= step_d;
      dir_q   <= dir_d;
      first_q <= first_d;
      rep_q   <= rep_d;
      plus_q  <= (step_d == S_PULSE) && (dir_d == DIR_PLUS);
      minus_q <= (step_d == S_PULSE) && (dir_d == DIR_MINUS);
    end
  end

  assign o_enable_1s = enable_q;
  assign o_state     = field_q;
  assign o_is_modify = (mode_q == MODE_MODIFY);
  assign o_plus      = plus_q;
  assign o_minus     = minus_q;

endmodule

// File: tb/tb_clock_control.sv
// Scoreboard bench for clock_control: expected output events are queued as
// stimulus is applied and matched against events seen on the outputs.
module tb_clock_control;
  import clock_pkg::*;

  localparam int DEB   = 4;
  localparam int TICK  = 10;
  localparam int PULSE = 2;
  localparam int RDLY  = 20;
  localparam int RRATE = 6;
  localparam int NF    = 6;

  // Raw edge to effect of a press: DEB+2 to debounce, +1 for the strobe.
  localparam int LAT = DEB + 3;

  localparam int EV_EN_FALL    = 0;
  localparam int EV_PLUS_RISE  = 1;
  localparam int EV_PLUS_FALL  = 2;
  localparam int EV_MINUS_RISE = 3;
  localparam int EV_MINUS_FALL = 4;
  localparam int EV_MOD        = 5;
  localparam int EV_STATE      = 6;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic               clk = 1'b0;
  logic               i_reset;
  logic               i_btn_modify = 1'b0;
  logic               i_btn_mode   = 1'b0;
  logic               i_btn_plus   = 1'b0;
  logic               i_btn_minus  = 1'b0;
  logic               o_enable_1s, o_is_modify, o_plus, o_minus;
  logic [STATE_W-1:0] o_state;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  tick_mon = 1'b0;
  int  rep_rel[5] = '{1, 21, 27, 33, 39};

  clock_control #(
    .DEBOUNCE_MS(DEB), .TICK_MS(TICK), .PULSE_MS(PULSE),
    .REPEAT_DELAY_MS(RDLY), .REPEAT_RATE_MS(RRATE), .NUM_FIELDS(NF)
  ) dut (
    .i_clk_0_001s(clk),
    .i_reset     (i_reset),
    .i_btn_modify(i_btn_modify),
    .i_btn_mode  (i_btn_mode),
    .i_btn_plus  (i_btn_plus),
    .i_btn_minus (i_btn_minus),
    .o_enable_1s (o_enable_1s),
    .o_state     (o_state),
    .o_is_modify (o_is_modify),
    .o_plus      (o_plus),
    .o_minus     (o_minus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int val, input int at);
    exp_q.push_back('{kind, val, at});
  endtask

  task automatic note_ev(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_ev%0d", kind), val, -1);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("ev%0d_kind", e.kind), kind, e.kind);
    check($sformatf("ev%0d_val", e.kind), val, e.val);
    check($sformatf("ev%0d_cyc", e.kind), cyc, e.cyc);
  endtask

  // Output monitor, sampled mid-cycle.
  logic               p_en = 1'b0, p_plus = 1'b0, p_minus = 1'b0, p_mod = 1'b0;
  logic [STATE_W-1:0] p_state = '0;

  always @(negedge clk) begin
    if (tick_mon && p_en && !o_enable_1s) note_ev(EV_EN_FALL, 0);
    if (o_plus !== p_plus) note_ev(o_plus ? EV_PLUS_RISE : EV_PLUS_FALL, 0);
    if (o_minus !== p_minus) note_ev(o_minus ? EV_MINUS_RISE : EV_MINUS_FALL, 0);
    if (o_is_modify !== p_mod) note_ev(EV_MOD, int'(o_is_modify));
    if (o_state !== p_state) note_ev(EV_STATE, int'(o_state));
    if (o_plus || o_minus) check("plus_minus_excl", int'(o_plus & o_minus), 0);
    p_en    = o_enable_1s;
    p_plus  = o_plus;
    p_minus = o_minus;
    p_mod   = o_is_modify;
    p_state = o_state;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clean press of the modify button, expecting o_is_modify to reach new_mod.
  task automatic press_modify(input int new_mod);
    expect_ev(EV_MOD, new_mod, cyc + LAT);
    i_btn_modify = 1'b1;
    wait_cyc(8);
    i_btn_modify = 1'b0;
    wait_cyc(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int b;
    i_reset = 1'b1;
    wait_cyc(3);
    check("rst_enable", int'(o_enable_1s), 0);
    check("rst_state", int'(o_state), 0);
    check("rst_modify", int'(o_is_modify), 0);
    check("rst_plus", int'(o_plus), 0);
    check("rst_minus", int'(o_minus), 0);

    // Tick: falls at 5, 15, 25 after release.
    i_reset = 1'b0;
    b = cyc;
    tick_mon = 1'b1;
    expect_ev(EV_EN_FALL, 0, b + 5);
    expect_ev(EV_EN_FALL, 0, b + 15);
    expect_ev(EV_EN_FALL, 0, b + 25);
    wait_cyc(33);
    tick_mon = 1'b0;

    // Bounce rejection on modify.
    for (int i = 0; i < 10; i++) begin
      i_btn_modify = ((i / 2) % 2) == 0;
      wait_cyc(1);
    end
    i_btn_modify = 1'b0;
    wait_cyc(10);
    check("bounce_no_modify", int'(o_is_modify), 0);
    expect_ev(EV_MOD, 1, cyc + LAT);
    i_btn_modify = 1'b1;
    wait_cyc(8);
    check("hold_modify", int'(o_is_modify), 1);
    check("hold_state", int'(o_state), 0);
    i_btn_modify = 1'b0;
    wait_cyc(10);

    // Field cycling: 1,2,3,4,5,0.
    for (int k = 1; k <= 6; k++) begin
      expect_ev(EV_STATE, k % NF, cyc + LAT);
      i_btn_mode = 1'b1;
      wait_cyc(8);
      i_btn_mode = 1'b0;
      wait_cyc(8);
    end
    press_modify(0);
    i_btn_mode = 1'b1;
    wait_cyc(8);
    i_btn_mode = 1'b0;
    wait_cyc(8);
    check("idle_mode_ignored", int'(o_state), 0);

    // Auto-repeat on plus.
    press_modify(1);
    b = cyc + DEB + 2;
    i_btn_plus = 1'b1;
    foreach (rep_rel[i]) begin
      expect_ev(EV_PLUS_RISE, 0, b + rep_rel[i]);
      expect_ev(EV_PLUS_FALL, 0, b + rep_rel[i] + PULSE);
    end
    wait_cyc(40);
    i_btn_plus = 1'b0;
    wait_cyc(20);

    // Both buttons together: nothing.
    i_btn_plus  = 1'b1;
    i_btn_minus = 1'b1;
    wait_cyc(30);
    i_btn_plus  = 1'b0;
    i_btn_minus = 1'b0;
    wait_cyc(10);

    // Minus held, modify exit lands mid-pulse: pulse completes, no more steps.
    b = cyc;
    i_btn_minus = 1'b1;
    expect_ev(EV_MINUS_RISE, 0, b + LAT);
    expect_ev(EV_MOD, 0, b + LAT + 1);
    expect_ev(EV_MINUS_FALL, 0, b + LAT + PULSE);
    wait_cyc(1);
    i_btn_modify = 1'b1;
    wait_cyc(8);
    i_btn_modify = 1'b0;
    wait_cyc(22);
    i_btn_minus = 1'b0;
    wait_cyc(10);

    // Async reset in the middle of the second repeat pulse.
    press_modify(1);
    b = cyc;
    i_btn_plus = 1'b1;
    expect_ev(EV_PLUS_RISE, 0, b + LAT);
    expect_ev(EV_PLUS_FALL, 0, b + LAT + PULSE);
    expect_ev(EV_PLUS_RISE, 0, b + LAT + RDLY);
    expect_ev(EV_PLUS_FALL, 0, b + LAT + RDLY + 1);
    expect_ev(EV_MOD, 0, b + LAT + RDLY + 1);
    wait_cyc(LAT + RDLY + 1);
    check("mid_pulse_high", int'(o_plus), 1);
    i_reset = 1'b1;
    #1;
    check("async_plus", int'(o_plus), 0);
    check("async_minus", int'(o_minus), 0);
    check("async_modify", int'(o_is_modify), 0);
    check("async_state", int'(o_state), 0);
    check("async_enable", int'(o_enable_1s), 0);
    wait_cyc(3);
    i_reset = 1'b0;
    wait_cyc(10);
    press_modify(1);
    check("no_step_without_press", int'(o_plus), 0);
    i_btn_plus = 1'b0;
    wait_cyc(10);
    b = cyc;
    i_btn_plus = 1'b1;
    expect_ev(EV_PLUS_RISE, 0, b + LAT);
    expect_ev(EV_PLUS_FALL, 0, b + LAT + PULSE);
    wait_cyc(10);
    i_btn_plus = 1'b0;
    wait_cyc(20);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
